// File: rtl/flog2_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : flog2_seq_ctrl
// Brief    : Multi-cycle floor(log2) of a WIDTH-bit operand. Scans the
//            operand one byte per cycle, MSB byte first, through an 8-bit
//            flog2 encoder and stops at the first nonzero byte. Valid/ready
//            handshakes on both the operand side and the result side.
// Revision : 1.0 - initial release
// ============================================================================
module flog2_seq_ctrl #(
  parameter  int WIDTH  = 32,
  localparam int NBYTES = WIDTH / 8,
  localparam int YW     = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] b_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [YW-1:0]    y_o,
  output logic             zero_o,
  output logic             busy_o
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] C_IDX_TOP = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  op_q,    op_d;
  logic [IW-1:0]     idx_q,   idx_d;
  logic [YW-1:0]     y_q,     y_d;
  logic              zero_q,  zero_d;

  logic [WIDTH-1:0]  w_shift;
  logic [7:0]        w_byte;
  logic [2:0]        w_enc;
  logic [YW-1:0]     w_y;

  // 8-bit flog2 byte encoder: position of the highest set bit (0 for 0).
  function automatic logic [2:0] flog2_8(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Select the byte under scan and build idx*8 + enc in YW bits (max WIDTH-1).
  always_comb begin
    w_shift = op_q >> {idx_q, 3'b000};
    w_byte  = w_shift[7:0];
    w_enc   = flog2_8(w_byte);
    w_y     = (YW'(idx_q) << 3) | YW'(w_enc);
  end

  // State and datapath registers; everything clears asynchronously on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      op_q    <= '0;
      idx_q   <= C_IDX_TOP;
      y_q     <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
    end
  end

  // Next-state logic: accept in IDLE, walk bytes downward in SCAN, hold in DONE.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    y_d     = y_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          op_d    = b_i;
          idx_d   = C_IDX_TOP;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (w_byte != 8'd0) begin
          y_d     = w_y;
          zero_d  = 1'b0;
          state_d = DONE;
        end else if (idx_q == '0) begin
          y_d     = '0;
          zero_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d   = idx_q - 1'b1;
        end
      end
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs come from registers/state only; ready_o is also gated by reset.
  always_comb begin
    ready_o = rst_ni && (state_q == IDLE);
    valid_o = (state_q == DONE);
    busy_o  = (state_q != IDLE);
    y_o     = y_q;
    zero_o  = zero_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_flog2_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_flog2_seq_ctrl
// Brief    : Directed self-checking bench for flog2_seq_ctrl (WIDTH = 32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_flog2_seq_ctrl;

  logic        clk_i;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] b_i;
  logic        valid_o;
  logic        ready_i;
  logic [4:0]  y_o;
  logic        zero_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  flog2_seq_ctrl #(.WIDTH(32)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .b_i     (b_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .y_o     (y_o),
    .zero_o  (zero_o),
    .busy_o  (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and settle 1 ns after it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present one operand, wait (bounded) for valid_o with ready_i low.
  // lat = 1 + edges after the accept edge; -1 if the bound expired.
  task automatic do_op(input logic [31:0] b, output int lat,
                       output logic [4:0] y, output logic z);
    valid_i = 1'b1; b_i = b; ready_i = 1'b0;
    step();
    valid_i = 1'b0; b_i = '0;
    lat = 1;
    while (!valid_o && lat < 20) begin
      step();
      lat++;
    end
    if (!valid_o) lat = -1;
    y = y_o;
    z = zero_o;
  endtask

  // Complete the result handshake; leaves the bench one cycle later in IDLE.
  task automatic take_result();
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b0; b_i = '0;
    #2;
    n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL rst_ready got=%b exp=0", ready_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%b exp=0", valid_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    n_cmp++; if (y_o !== 5'd0 || zero_o !== 1'b0) begin n_bad++; $display("FAIL rst_y got=%0d/%b exp=0/0", y_o, zero_o); end
    step();
    step();
    rst_ni = 1'b1;
    #1;
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready got=%b exp=1", ready_o); end
    step();
  endtask

  task automatic test_msb();
    int lat; logic [4:0] y; logic z;
    do_op(32'h8000_0000, lat, y, z);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL msb_lat got=%0d exp=2", lat); end
    n_cmp++; if (y !== 5'd31 || z !== 1'b0) begin n_bad++; $display("FAIL msb_y got=%0d/%b exp=31/0", y, z); end
    n_cmp++; if (ready_o !== 1'b0 || busy_o !== 1'b1) begin n_bad++; $display("FAIL msb_done_flags got=%b/%b exp=0/1", ready_o, busy_o); end
    take_result();
    n_cmp++; if (ready_o !== 1'b1 || valid_o !== 1'b0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL msb_after rdy/vld/busy got=%b/%b/%b exp=1/0/0", ready_o, valid_o, busy_o); end
  endtask

  task automatic test_mid();
    int lat; logic [4:0] y; logic z;
    do_op(32'h0001_2345, lat, y, z);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL mid1_lat got=%0d exp=3", lat); end
    n_cmp++; if (y !== 5'd16 || z !== 1'b0) begin n_bad++; $display("FAIL mid1_y got=%0d/%b exp=16/0", y, z); end
    take_result();
    do_op(32'h0000_00FF, lat, y, z);
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL mid2_lat got=%0d exp=5", lat); end
    n_cmp++; if (y !== 5'd7 || z !== 1'b0) begin n_bad++; $display("FAIL mid2_y got=%0d/%b exp=7/0", y, z); end
    take_result();
    do_op(32'h0000_3000, lat, y, z);
    n_cmp++; if (lat !== 4 || y !== 5'd13) begin n_bad++; $display("FAIL mid3 lat/y got=%0d/%0d exp=4/13", lat, y); end
    take_result();
  endtask

  task automatic test_zero();
    int lat; logic [4:0] y; logic z;
    do_op(32'h0000_0000, lat, y, z);
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL zero_lat got=%0d exp=5", lat); end
    n_cmp++; if (y !== 5'd0 || z !== 1'b1) begin n_bad++; $display("FAIL zero_y got=%0d/%b exp=0/1", y, z); end
    take_result();
    do_op(32'h0000_0001, lat, y, z);
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL one_lat got=%0d exp=5", lat); end
    n_cmp++; if (y !== 5'd0 || z !== 1'b0) begin n_bad++; $display("FAIL one_y got=%0d/%b exp=0/0", y, z); end
    take_result();
  endtask

  task automatic test_backpressure();
    int lat; logic [4:0] y; logic z;
    valid_i = 1'b1; b_i = 32'h0040_0000; ready_i = 1'b0;
    step();
    b_i = 32'hFFFF_FFFF;
    n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL bp_scan_ready got=%b exp=0", ready_o); end
    lat = 1;
    while (!valid_o && lat < 20) begin
      step();
      lat++;
    end
    n_cmp++; if (lat !== 3 || y_o !== 5'd22) begin n_bad++; $display("FAIL bp_first lat/y got=%0d/%0d exp=3/22", lat, y_o); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (valid_o !== 1'b1 || y_o !== 5'd22 || zero_o !== 1'b0 || ready_o !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold%0d vld/y/z/rdy got=%b/%0d/%b/%b exp=1/22/0/0", i, valid_o, y_o, zero_o, ready_o);
      end
    end
    valid_i = 1'b0; b_i = '0;
    take_result();
    n_cmp++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin n_bad++; $display("FAIL bp_release vld/rdy got=%b/%b exp=0/1", valid_o, ready_o); end
    do_op(32'h0000_0004, lat, y, z);
    n_cmp++; if (lat !== 5 || y !== 5'd2 || z !== 1'b0) begin n_bad++; $display("FAIL bp_next lat/y/z got=%0d/%0d/%b exp=5/2/0", lat, y, z); end
    take_result();
  endtask

  task automatic test_back_to_back();
    int n;
    valid_i = 1'b1; b_i = 32'h0000_0100; ready_i = 1'b1;
    step();
    n = 1;
    while (!valid_o && n < 20) begin
      step();
      n++;
    end
    n_cmp++; if (n !== 4 || y_o !== 5'd8) begin n_bad++; $display("FAIL b2b_first lat/y got=%0d/%0d exp=4/8", n, y_o); end
    b_i = 32'h8000_0000;
    step();
    n_cmp++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin n_bad++; $display("FAIL b2b_idle vld/rdy got=%b/%b exp=0/1", valid_o, ready_o); end
    step();
    valid_i = 1'b0; b_i = '0;
    n_cmp++; if (busy_o !== 1'b1 || ready_o !== 1'b0) begin n_bad++; $display("FAIL b2b_accept busy/rdy got=%b/%b exp=1/0", busy_o, ready_o); end
    step();
    n_cmp++; if (valid_o !== 1'b1 || y_o !== 5'd31) begin n_bad++; $display("FAIL b2b_second vld/y got=%b/%0d exp=1/31", valid_o, y_o); end
    step();
    ready_i = 1'b0;
    n_cmp++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin n_bad++; $display("FAIL b2b_end rdy/vld got=%b/%b exp=1/0", ready_o, valid_o); end
  endtask

  task automatic test_async_reset();
    int lat; logic [4:0] y; logic z;
    valid_i = 1'b1; b_i = 32'h0000_0010; ready_i = 1'b0;
    step();
    valid_i = 1'b0; b_i = '0;
    step();
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL ar_scan busy got=%b exp=1", busy_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (busy_o !== 1'b0 || ready_o !== 1'b0 || valid_o !== 1'b0 || y_o !== 5'd0 || zero_o !== 1'b0) begin
      n_bad++; $display("FAIL ar_mid busy/rdy/vld/y/z got=%b/%b/%b/%0d/%b exp=0/0/0/0/0", busy_o, ready_o, valid_o, y_o, zero_o);
    end
    step();
    rst_ni = 1'b1;
    #1;
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL ar_release ready got=%b exp=1", ready_o); end
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL ar_stale%0d vld/busy got=%b/%b exp=0/0", i, valid_o, busy_o); end
    end
    do_op(32'h0000_0004, lat, y, z);
    n_cmp++; if (lat !== 5 || y !== 5'd2 || z !== 1'b0) begin n_bad++; $display("FAIL ar_new lat/y/z got=%0d/%0d/%b exp=5/2/0", lat, y, z); end
    take_result();
  endtask

  initial begin
    test_reset();
    test_msb();
    test_mid();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/flog2_seq_ctrl.md
Name: flog2_seq_ctrl

Overview:
- Multi-cycle controller that computes floor(log2) of a WIDTH-bit operand by reusing the existing 8-bit flog2 byte encoder.
- The operand is scanned byte by byte, starting with the MSB byte, and the scan stops at the first nonzero byte.
- A valid/ready handshake is used on both the operand side and the result side, so the block can sit between ALU stages that tolerate variable latency.

Parameters:
- WIDTH, 32, operand width in bits. Must be a multiple of 8 and at least 8.
- NBYTES, WIDTH/8, number of byte slices. Derived; do not override.
- YW, $clog2(WIDTH), result width. Derived; minimum 3.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- valid_i  in  1  operand valid.
- ready_o  out  1  controller can accept an operand.
- b_i  in  WIDTH  operand.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- y_o  out  YW  floor(log2(operand)); 0 when the operand is 0.
- zero_o  out  1  operand was 0.
- busy_o  out  1  state is not IDLE.

Behaviour:
- One clock. Reset is asynchronous and active-low (rst_ni). All state registers are cleared on the falling edge of rst_ni, independent of clk_i.
- Reset values:
  - state = IDLE, op_q = 0, idx_q = NBYTES-1.
  - y_o = 0, zero_o = 0, valid_o = 0, busy_o = 0.
  - ready_o = 0 while rst_ni is low; ready_o = 1 from the first cycle after reset is released.
- State machine, three states: IDLE, SCAN, DONE.
- IDLE:
  - ready_o = 1.
  - On valid_i && ready_o at a clock edge: op_q <= b_i, idx_q <= NBYTES-1, go to SCAN.
  - b_i is ignored in every cycle without a handshake.
- SCAN:
  - ready_o = 0 and busy_o = 1.
  - Each cycle, op_q[idx_q*8 +: 8] feeds the flog2 encoder. Only the encoder's low 3 output bits are used.
  - If the byte is nonzero: y_o <= idx_q*8 + enc[2:0], zero_o <= 0, go to DONE.
  - Else if idx_q == 0: y_o <= 0, zero_o <= 1, go to DONE.
  - Else: idx_q <= idx_q - 1, stay in SCAN.
- DONE:
  - valid_o = 1, ready_o = 0, busy_o = 1.
  - y_o and zero_o are registered and held stable while valid_o && !ready_i.
  - On ready_i: go to IDLE. valid_o falls and ready_o rises in the next cycle.
  - A new operand cannot be accepted in the same cycle as the result handshake.
- Latency, counted from the input-handshake edge to the first cycle with valid_o high:
  - 1 + (NBYTES - k), where k is the index of the highest nonzero byte.
  - 1 + NBYTES for a zero operand.
  - For WIDTH = 32 this is 2 to 5 cycles.
- Throughput: one operation in flight at a time. There is no overlap between the scan and the result hold.
- Arithmetic: idx_q*8 + enc[2:0] is formed in YW bits and cannot overflow, since the maximum is WIDTH-1.
- ready_i outside DONE has no effect. valid_i outside IDLE has no effect, and the operand is not captured.
- Reset mid-operation (in SCAN or DONE): the block returns to IDLE immediately with all outputs at their reset values. The in-flight result is discarded and never presented.
- valid_o, y_o, zero_o and busy_o are driven from registers or state only, with no combinational path from inputs. ready_o depends only on state and rst_ni.

Test Plan:
1. WIDTH=32, b_i=0x8000_0000, ready_i=1 → valid_o high 2 cycles after accept; y_o=31, zero_o=0; ready_o high in the following cycle.
2. b_i=0x0001_2345 → valid_o after 3 cycles, y_o=16. Then b_i=0x0000_00FF → valid_o after 5 cycles, y_o=7.
3. b_i=0x0000_0000 → valid_o after 5 cycles, y_o=0, zero_o=1. Then b_i=0x0000_0001 → valid_o after 5 cycles, y_o=0, zero_o=0.
4. Backpressure: b_i=0x0040_0000 with ready_i low for 4 cycles in DONE → y_o=22 and valid_o held constant. valid_i pulsed with 0xFFFF_FFFF during SCAN/DONE is not accepted (ready_o=0), and the next result reflects only operands accepted in IDLE.
5. Back-to-back: valid_i held high with 0x0000_0100 then 0x8000_0000 → results y_o=8 then y_o=31, one idle cycle between the result handshake and the next accept.
6. Reset: assert rst_ni low asynchronously (mid-cycle) during SCAN of 0x0000_0010 → all outputs reset immediately; after release, ready_o=1, no stale valid_o; a new operand 0x0000_0004 gives y_o=2.
